// File: rtl/rr_arb_mux_pkg.sv
// Shared types and helpers for the round-robin arbitrating mux.
package rr_arb_mux_pkg;

  typedef enum logic {
    StArb    = 1'b0,
    StLocked = 1'b1
  } state_e;

  // Source-index width: clog2(n), but never narrower than one bit.
  function automatic int unsigned sel_width(int unsigned n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request scanning ptr, ptr+1, ... modulo N.
module rr_pick
  import rr_arb_mux_pkg::*;
#(
  parameter int unsigned N    = 4,
  parameter int unsigned SELW = sel_width(N)
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] ptr,
  output logic            found,
  output logic [SELW-1:0] idx
);

  // Scan from the far end back to ptr so the closest request is the last one written.
  always_comb begin
    int c;
    found = 1'b0;
    idx   = '0;
    c     = 0;
    for (int k = int'(N) - 1; k >= 0; k--) begin
      c = (int'(ptr) + k) % int'(N);
      if (req[c]) begin
        found = 1'b1;
        idx   = SELW'(c);
      end
    end
  end

endmodule

// File: rtl/rr_arb_mux.sv
// N-way valid/ready arbiter with round-robin fairness, burst lock on in_last and a registered output.
module rr_arb_mux
  import rr_arb_mux_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned N     = 4,
  localparam int unsigned SELW = sel_width(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N-1:0]       in_valid,
  input  logic [N-1:0]       in_last,
  input  logic [N*WIDTH-1:0] in_data,
  output logic [N-1:0]       in_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_last,
  output logic [SELW-1:0]    out_src,
  input  logic               out_ready
);

  state_e            state_q, state_d;
  logic [SELW-1:0]   ptr_q, ptr_d;
  logic [SELW-1:0]   lock_q, lock_d;
  logic [SELW-1:0]   pick_idx, grant, grant_inc;
  logic              pick_found, grant_vld;
  logic              load_ok, xfer, grant_last;
  logic [WIDTH-1:0]  grant_data;
  logic              out_valid_q;
  logic [WIDTH-1:0]  out_data_q;
  logic              out_last_q;
  logic [SELW-1:0]   out_src_q;

  rr_pick #(
    .N    (N),
    .SELW (SELW)
  ) u_pick (
    .req   (in_valid),
    .ptr   (ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // While locked the grant stays on lock_q even if that channel goes idle mid-burst.
  assign grant      = (state_q == StLocked) ? lock_q : pick_idx;
  assign grant_vld  = (state_q == StLocked) | pick_found;
  assign grant_inc  = (grant == SELW'(N - 1)) ? '0 : grant + SELW'(1);
  assign load_ok    = ~out_valid_q | out_ready;
  assign xfer       = grant_vld & load_ok & ~rst & in_valid[grant];
  assign grant_last = in_last[grant];
  assign grant_data = in_data[int'(grant)*WIDTH +: WIDTH];

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StArb;
      ptr_q   <= '0;
      lock_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      lock_q  <= lock_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    lock_d  = lock_q;
    if (xfer) begin
      if (grant_last) begin
        state_d = StArb;
        ptr_d   = grant_inc;
      end else if (state_q == StArb) begin
        state_d = StLocked;
        lock_d  = grant;
      end
    end
  end

  // Output logic: single one-hot accept toward the granted channel
  always_comb begin
    in_ready = '0;
    if (grant_vld && load_ok && !rst) begin
      in_ready[grant] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_src_q   <= '0;
    end else if (xfer) begin
      out_valid_q <= 1'b1;
      out_data_q  <= grant_data;
      out_last_q  <= grant_last;
      out_src_q   <= grant;
    end else if (out_valid_q && out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign out_src   = out_src_q;

endmodule

// File: tb/tb_rr_arb_mux.sv
// Directed bench for rr_arb_mux: a 4-way instance for most scenarios, a 3-way one for wrap/reset.
module tb_rr_arb_mux;

  localparam int unsigned W = 32;

  logic clk;
  int   checks;
  int   errors;

  logic           rst4, rst3;
  logic [3:0]     v4, l4, r4;
  logic [4*W-1:0] d4;
  logic           ov4, ol4, ordy4;
  logic [W-1:0]   od4;
  logic [1:0]     os4;
  logic [2:0]     v3, l3, r3;
  logic [3*W-1:0] d3;
  logic           ov3, ol3, ordy3;
  logic [W-1:0]   od3;
  logic [1:0]     os3;

  rr_arb_mux #(.WIDTH(W), .N(4)) dut4 (
    .clk(clk), .rst(rst4), .in_valid(v4), .in_last(l4), .in_data(d4), .in_ready(r4),
    .out_valid(ov4), .out_data(od4), .out_last(ol4), .out_src(os4), .out_ready(ordy4)
  );

  rr_arb_mux #(.WIDTH(W), .N(3)) dut3 (
    .clk(clk), .rst(rst3), .in_valid(v3), .in_last(l3), .in_data(d3), .in_ready(r3),
    .out_valid(ov3), .out_data(od3), .out_last(ol3), .out_src(os3), .out_ready(ordy3)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst4 = 1'b1; v4 = 4'hF; l4 = 4'hF; ordy4 = 1'b1;
    #1;
    checks++;
    if (r4 !== 4'b0000) begin
      errors++; $display("FAIL reset_ready got %b want 0000", r4);
    end
    tick();
    checks++;
    if (ov4 !== 1'b0) begin
      errors++; $display("FAIL reset_out_valid got %b want 0", ov4);
    end
    rst4 = 1'b0; v4 = 4'h0; l4 = 4'h0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (r4 !== 4'b0000 || ov4 !== 1'b0 || os4 !== 2'd0) begin
        errors++;
        $display("FAIL idle_after_reset cyc %0d got rdy=%b ov=%b src=%0d want 0000/0/0",
                 i, r4, ov4, os4);
      end
    end
  endtask

  task automatic test_round_robin();
    logic [3:0]   exp_r;
    logic [W-1:0] exp_d;
    int           g;
    for (int i = 0; i < 4; i++) d4[i*W +: W] = 32'hA0 + 32'(i);
    v4 = 4'hF; l4 = 4'hF; ordy4 = 1'b1;
    for (int k = 0; k < 5; k++) begin
      g = k % 4;
      exp_r = 4'b0001 << g;
      exp_d = 32'hA0 + 32'(g);
      #1;
      checks++;
      if (r4 !== exp_r) begin
        errors++; $display("FAIL rr_ready beat %0d got %b want %b", k, r4, exp_r);
      end
      tick();
      checks++;
      if (ov4 !== 1'b1 || os4 !== 2'(g) || od4 !== exp_d) begin
        errors++;
        $display("FAIL rr_out beat %0d got v=%b src=%0d data=%h want 1/%0d/%h",
                 k, ov4, os4, od4, g, exp_d);
      end
    end
    v4 = 4'h0;
    tick();
    checks++;
    if (ov4 !== 1'b0) begin
      errors++; $display("FAIL rr_drain got %b want 0", ov4);
    end
  endtask

  // Pointer is 1 here: channel 2 wins first and locks for three beats.
  task automatic test_burst();
    int           exp_src [5] = '{2, 2, 2, 3, 0};
    logic [W-1:0] exp_dat [5] = '{32'hB0, 32'hB1, 32'hB2, 32'hA3, 32'hA0};
    logic         exp_lst [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [3:0]   exp_r;
    for (int b = 0; b < 5; b++) begin
      v4 = (b < 3) ? 4'b1101 : 4'b1001;
      l4 = {1'b1, (b == 2), 1'b0, 1'b1};
      d4[2*W +: W] = 32'hB0 + 32'(b);
      exp_r = 4'b0001 << exp_src[b];
      #1;
      checks++;
      if (r4 !== exp_r) begin
        errors++; $display("FAIL burst_ready beat %0d got %b want %b", b, r4, exp_r);
      end
      tick();
      checks++;
      if (ov4 !== 1'b1 || os4 !== 2'(exp_src[b]) || od4 !== exp_dat[b] || ol4 !== exp_lst[b]) begin
        errors++;
        $display("FAIL burst_out beat %0d got src=%0d data=%h last=%b want %0d/%h/%b",
                 b, os4, od4, ol4, exp_src[b], exp_dat[b], exp_lst[b]);
      end
    end
    v4 = 4'h0;
    tick();
  endtask

  task automatic test_backpressure();
    v4 = 4'b0010; l4 = 4'b0010; d4[1*W +: W] = 32'hC1; ordy4 = 1'b1;
    #1;
    checks++;
    if (r4 !== 4'b0010) begin
      errors++; $display("FAIL bp_first_ready got %b want 0010", r4);
    end
    tick();
    ordy4 = 1'b0; d4[1*W +: W] = 32'hC2;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (r4 !== 4'b0000) begin
        errors++; $display("FAIL bp_ready cyc %0d got %b want 0000", i, r4);
      end
      tick();
      checks++;
      if (ov4 !== 1'b1 || od4 !== 32'hC1 || os4 !== 2'd1) begin
        errors++;
        $display("FAIL bp_hold cyc %0d got v=%b data=%h src=%0d want 1/c1/1", i, ov4, od4, os4);
      end
    end
    ordy4 = 1'b1;
    #1;
    checks++;
    if (r4 !== 4'b0010) begin
      errors++; $display("FAIL bp_release_ready got %b want 0010", r4);
    end
    tick();
    checks++;
    if (ov4 !== 1'b1 || od4 !== 32'hC2) begin
      errors++; $display("FAIL bp_next_beat got v=%b data=%h want 1/c2", ov4, od4);
    end
    v4 = 4'h0;
    tick();
    checks++;
    if (ov4 !== 1'b0) begin
      errors++; $display("FAIL bp_no_dup got %b want 0", ov4);
    end
  endtask

  task automatic test_lock_hold();
    v4 = 4'b0010; l4 = 4'b0000; d4[1*W +: W] = 32'hD0; d4[0 +: W] = 32'hE0;
    #1;
    tick();
    checks++;
    if (os4 !== 2'd1 || od4 !== 32'hD0 || ol4 !== 1'b0) begin
      errors++; $display("FAIL lock_first got src=%0d data=%h last=%b want 1/d0/0", os4, od4, ol4);
    end
    v4 = 4'b0001; l4 = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (r4 !== 4'b0010) begin
        errors++; $display("FAIL lock_hold_ready cyc %0d got %b want 0010", i, r4);
      end
      tick();
      checks++;
      if (ov4 !== 1'b0) begin
        errors++; $display("FAIL lock_hold_out cyc %0d got %b want 0", i, ov4);
      end
    end
    v4 = 4'b0011; l4 = 4'b0011; d4[1*W +: W] = 32'hD1;
    #1;
    checks++;
    if (r4 !== 4'b0010) begin
      errors++; $display("FAIL lock_last_ready got %b want 0010", r4);
    end
    tick();
    checks++;
    if (os4 !== 2'd1 || od4 !== 32'hD1 || ol4 !== 1'b1) begin
      errors++; $display("FAIL lock_last_out got src=%0d data=%h last=%b want 1/d1/1", os4, od4, ol4);
    end
    v4 = 4'b0001;
    #1;
    checks++;
    if (r4 !== 4'b0001) begin
      errors++; $display("FAIL unlock_ready got %b want 0001", r4);
    end
    tick();
    checks++;
    if (os4 !== 2'd0 || od4 !== 32'hE0) begin
      errors++; $display("FAIL unlock_out got src=%0d data=%h want 0/e0", os4, od4);
    end
    v4 = 4'h0;
    tick();
  endtask

  task automatic test_reset_mid_burst();
    logic [2:0] exp_r;
    int         g;
    rst3 = 1'b0; v3 = 3'b100; l3 = 3'b000; ordy3 = 1'b1;
    for (int b = 0; b < 2; b++) begin
      d3[2*W +: W] = 32'h20 + 32'(b);
      #1;
      checks++;
      if (r3 !== 3'b100) begin
        errors++; $display("FAIL n3_burst_ready beat %0d got %b want 100", b, r3);
      end
      tick();
      checks++;
      if (os3 !== 2'd2 || od3 !== 32'h20 + 32'(b)) begin
        errors++; $display("FAIL n3_burst_out beat %0d got src=%0d data=%h", b, os3, od3);
      end
    end
    rst3 = 1'b1; v3 = 3'b111; l3 = 3'b111;
    for (int i = 0; i < 3; i++) d3[i*W +: W] = 32'h30 + 32'(i);
    #1;
    checks++;
    if (r3 !== 3'b000) begin
      errors++; $display("FAIL n3_reset_ready got %b want 000", r3);
    end
    tick();
    checks++;
    if (ov3 !== 1'b0 || os3 !== 2'd0 || od3 !== 32'h0) begin
      errors++; $display("FAIL n3_reset_out got v=%b src=%0d data=%h want 0/0/0", ov3, os3, od3);
    end
    rst3 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      g = k % 3;
      exp_r = 3'b001 << g;
      #1;
      checks++;
      if (r3 !== exp_r) begin
        errors++; $display("FAIL n3_rr_ready beat %0d got %b want %b", k, r3, exp_r);
      end
      tick();
      checks++;
      if (ov3 !== 1'b1 || os3 !== 2'(g) || od3 !== 32'h30 + 32'(g)) begin
        errors++; $display("FAIL n3_rr_out beat %0d got src=%0d data=%h want %0d", k, os3, od3, g);
      end
    end
    v3 = 3'b000;
    tick();
  endtask

  initial begin
    checks = 0; errors = 0;
    clk = 1'b0;
    rst4 = 1'b1; rst3 = 1'b1;
    v4 = '0; l4 = '0; d4 = '0; ordy4 = 1'b1;
    v3 = '0; l3 = '0; d3 = '0; ordy3 = 1'b1;
    tick();
    tick();
    test_reset();
    test_round_robin();
    test_burst();
    test_backpressure();
    test_lock_hold();
    test_reset_mid_burst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
